// File: rtl/gbt_link_sequencer_pkg.sv
// Shared types and default constants for the GBT link bring-up sequencer.
package gbt_link_sequencer_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [2:0] {
    NO_SIGNAL = 3'd0,
    SETTLE    = 3'd1,
    WAIT_LOCK = 3'd2,
    BITSLIP   = 3'd3,
    LOCKED    = 3'd4,
    FAULT     = 3'd5
  } gbt_seq_state_t;

  localparam int unsigned GBT_SETTLE_CYCLES = 400;
  localparam int unsigned GBT_LOCK_TIMEOUT  = 400;
  localparam int unsigned GBT_BITSLIP_PULSE = 4;
  localparam int unsigned GBT_MAX_RETRIES   = 8;
  localparam int unsigned GBT_DROP_FILTER   = 3;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gbt_link_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous SFP LOS pin into the frame clock domain.
module sync_2ff
  import gbt_link_sequencer_pkg::*;
(
  input  ckrs_t ClkRs_ix,
  input  logic  d,
  output logic  q
);

  logic clk_s;
  logic meta_r;
  logic sync_r;

  assign clk_s = ClkRs_ix.clk;

  // metastability stage followed by the stable output stage
  always_ff @(posedge clk_s) begin
    if (ClkRs_ix.reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/gbt_link_sequencer.sv
// GBT link bring-up/supervision FSM: settle after LOS, wait for lock with bounded bitslip
// retries, gate user data while locked and re-train on loss of lock.
module gbt_link_sequencer
  import gbt_link_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = GBT_SETTLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = GBT_LOCK_TIMEOUT,
  parameter int unsigned BITSLIP_PULSE = GBT_BITSLIP_PULSE,
  parameter int unsigned MAX_RETRIES   = GBT_MAX_RETRIES,
  parameter int unsigned DROP_FILTER   = GBT_DROP_FILTER
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        sfp_los_i,
  input  logic        link_ready_i,
  input  logic        force_retrain_i,
  output logic        bitslip_reset_o,
  output logic        tx_data_en_o,
  output logic        link_up_o,
  output logic        fault_o,
  output logic [7:0]  retry_cnt_o,
  output logic [2:0]  state_o
);

  // the timer also times the bitslip pulse, so it must hold that load too
  localparam int TW = $clog2(max_of(max_of(SETTLE_CYCLES, LOCK_TIMEOUT), BITSLIP_PULSE) + 1);
  localparam int DW = $clog2(DROP_FILTER + 1);

  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] BITSLIP_LOAD = TW'(BITSLIP_PULSE - 1);
  localparam logic [7:0]    RETRY_MAX    = 8'(MAX_RETRIES);
  localparam logic [DW-1:0] DROP_LAST    = DW'(DROP_FILTER - 1);

  logic           clk_s;
  logic           los_s;
  gbt_seq_state_t state_r, state_s;
  logic [TW-1:0]  timer_r, timer_s;
  logic [7:0]     retry_r, retry_s;
  logic [DW-1:0]  drop_r, drop_s;
  logic           fault_r, fault_s;
  logic           bitslip_r, tx_en_r, link_up_r;

  assign clk_s = ClkRs_ix.clk;

  sync_2ff u_los_sync (
    .ClkRs_ix (ClkRs_ix),
    .d        (sfp_los_i),
    .q        (los_s)
  );

  // next-state, timer, retry and drop-filter decisions in priority order
  always_comb begin
    state_s = state_r;
    timer_s = (timer_r != {TW{1'b0}}) ? (timer_r - TW'(1'b1)) : {TW{1'b0}};
    retry_s = retry_r;
    drop_s  = {DW{1'b0}};
    fault_s = fault_r;
    if (los_s) begin
      state_s = NO_SIGNAL;
      timer_s = {TW{1'b0}};
      retry_s = 8'd0;
    end else if (force_retrain_i && (state_r != NO_SIGNAL)) begin
      state_s = SETTLE;
      timer_s = SETTLE_LOAD;
      retry_s = 8'd0;
      fault_s = 1'b0;
    end else begin
      case (state_r)
        NO_SIGNAL: begin
          state_s = SETTLE;
          timer_s = SETTLE_LOAD;
        end
        SETTLE: begin
          if (timer_r == {TW{1'b0}}) begin
            state_s = WAIT_LOCK;
            timer_s = LOCK_LOAD;
          end else begin
            state_s = SETTLE;
          end
        end
        WAIT_LOCK: begin
          if (link_ready_i) begin
            state_s = LOCKED;
          end else if (timer_r == {TW{1'b0}}) begin
            if (retry_r < RETRY_MAX) begin
              state_s = BITSLIP;
              timer_s = BITSLIP_LOAD;
              retry_s = retry_r + 8'd1;
            end else begin
              state_s = FAULT;
              fault_s = 1'b1;
            end
          end else begin
            state_s = WAIT_LOCK;
          end
        end
        BITSLIP: begin
          if (timer_r == {TW{1'b0}}) begin
            state_s = SETTLE;
            timer_s = SETTLE_LOAD;
          end else begin
            state_s = BITSLIP;
          end
        end
        LOCKED: begin
          if (!link_ready_i) begin
            if (drop_r == DROP_LAST) begin
              state_s = SETTLE;
              timer_s = SETTLE_LOAD;
              retry_s = 8'd0;
            end else begin
              drop_s = drop_r + DW'(1'b1);
            end
          end else begin
            drop_s = {DW{1'b0}};
          end
        end
        FAULT: begin
          fault_s = 1'b1;
        end
        default: begin
          state_s = NO_SIGNAL;
          timer_s = {TW{1'b0}};
          retry_s = 8'd0;
        end
      endcase
    end
  end

  // state, counters and output decode registered together so outputs track state_r exactly
  always_ff @(posedge clk_s) begin
    if (ClkRs_ix.reset) begin
      state_r   <= NO_SIGNAL;
      timer_r   <= {TW{1'b0}};
      retry_r   <= 8'd0;
      drop_r    <= {DW{1'b0}};
      fault_r   <= 1'b0;
      bitslip_r <= 1'b0;
      tx_en_r   <= 1'b0;
      link_up_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      retry_r   <= retry_s;
      drop_r    <= drop_s;
      fault_r   <= fault_s;
      bitslip_r <= (state_s == BITSLIP);
      tx_en_r   <= (state_s == LOCKED);
      link_up_r <= (state_s == LOCKED);
    end
  end

  assign bitslip_reset_o = bitslip_r;
  assign tx_data_en_o    = tx_en_r;
  assign link_up_o       = link_up_r;
  assign fault_o         = fault_r;
  assign retry_cnt_o     = retry_r;
  assign state_o         = state_r;

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Table-driven bench for gbt_link_sequencer with small timing parameters; expected values
// are hand-derived from the documented cycle timing of each state.
module tb_gbt_link_sequencer;
  import gbt_link_sequencer_pkg::*;

  typedef struct {
    string      name;
    logic       rst;
    logic       los;
    logic       rdy;
    logic       frc;
    int         ncyc;
    logic [2:0] st;
    logic       bs;
    logic       tx;
    logic       up;
    logic       flt;
    logic [7:0] retry;
    int         bsc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  ckrs_t      clk_rs;
  logic       sfp_los = 1'b1;
  logic       link_ready = 1'b0;
  logic       force_retrain = 1'b0;
  logic       bitslip_reset;
  logic       tx_data_en;
  logic       link_up;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  vec_t        vecs[$];
  logic [14:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          bs_hi_cnt = 0;
  int          bs_base = 0;

  assign clk_rs = '{clk: clk, reset: rst};

  always #5 clk = ~clk;

  gbt_link_sequencer #(
    .SETTLE_CYCLES (10),
    .LOCK_TIMEOUT  (20),
    .BITSLIP_PULSE (4),
    .MAX_RETRIES   (3),
    .DROP_FILTER   (3)
  ) dut (
    .ClkRs_ix        (clk_rs),
    .sfp_los_i       (sfp_los),
    .link_ready_i    (link_ready),
    .force_retrain_i (force_retrain),
    .bitslip_reset_o (bitslip_reset),
    .tx_data_en_o    (tx_data_en),
    .link_up_o       (link_up),
    .fault_o         (fault),
    .retry_cnt_o     (retry_cnt),
    .state_o         (state)
  );

  function automatic void add(input string n, input logic r, input logic l, input logic y,
                              input logic f, input int c, input logic [2:0] s, input logic b,
                              input logic t, input logic u, input logic fl, input logic [7:0] rc,
                              input int bc);
    vec_t v;
    v.name = n; v.rst = r; v.los = l; v.rdy = y; v.frc = f; v.ncyc = c;
    v.st = s; v.bs = b; v.tx = t; v.up = u; v.flt = fl; v.retry = rc; v.bsc = bc;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bitslip_reset) bs_hi_cnt++;
  endtask

  initial begin
    logic [14:0] exp_v;
    logic [14:0] act_v;
    //   name            rst los rdy frc  n   st bs tx up flt retry bsc
    add("reset",          1, 1, 0, 0,  3,  0, 0, 0, 0, 0, 8'd0, -1);
    add("los_held",       0, 1, 0, 0,  4,  0, 0, 0, 0, 0, 8'd0, -1);
    add("los_sync",       0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 8'd0, -1);
    add("to_settle",      0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 8'd0, -1);
    add("settle_ign_rdy", 0, 0, 1, 0,  9,  1, 0, 0, 0, 0, 8'd0, -1);
    add("to_wait",        0, 0, 0, 0,  1,  2, 0, 0, 0, 0, 8'd0, -1);
    add("wait",           0, 0, 0, 0, 14,  2, 0, 0, 0, 0, 8'd0, -1);
    add("lock",           0, 0, 1, 0,  1,  4, 0, 1, 1, 0, 8'd0,  0);
    add("glitch2",        0, 0, 0, 0,  2,  4, 0, 1, 1, 0, 8'd0, -1);
    add("recover",        0, 0, 1, 0,  1,  4, 0, 1, 1, 0, 8'd0, -1);
    add("low2",           0, 0, 0, 0,  2,  4, 0, 1, 1, 0, 8'd0, -1);
    add("drop",           0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 8'd0, -1);
    add("ex_wait1",       0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 8'd0, -1);
    add("ex_pre1",        0, 0, 0, 0, 19,  2, 0, 0, 0, 0, 8'd0, -1);
    add("bs1_start",      0, 0, 0, 0,  1,  3, 1, 0, 0, 0, 8'd1, -1);
    add("bs1_hold",       0, 0, 0, 0,  3,  3, 1, 0, 0, 0, 8'd1, -1);
    add("bs1_end",        0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 8'd1, -1);
    add("ex_wait2",       0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 8'd1, -1);
    add("bs2_start",      0, 0, 0, 0, 20,  3, 1, 0, 0, 0, 8'd2, -1);
    add("bs2_end",        0, 0, 0, 0,  4,  1, 0, 0, 0, 0, 8'd2, -1);
    add("ex_wait3",       0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 8'd2, -1);
    add("bs3_start",      0, 0, 0, 0, 20,  3, 1, 0, 0, 0, 8'd3, -1);
    add("bs3_end",        0, 0, 0, 0,  4,  1, 0, 0, 0, 0, 8'd3, -1);
    add("ex_wait4",       0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 8'd3, -1);
    add("ex_pre4",        0, 0, 0, 0, 19,  2, 0, 0, 0, 0, 8'd3, -1);
    add("fault",          0, 0, 0, 0,  1,  5, 0, 0, 0, 1, 8'd3, 12);
    add("fault_hold",     0, 0, 0, 0,  5,  5, 0, 0, 0, 1, 8'd3, -1);
    add("force_fault",    0, 0, 0, 1,  1,  1, 0, 0, 0, 0, 8'd0, -1);
    add("col_wait",       0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 8'd0, -1);
    add("col_pre",        0, 0, 0, 0, 19,  2, 0, 0, 0, 0, 8'd0, -1);
    add("collision",      0, 0, 1, 0,  1,  4, 0, 1, 1, 0, 8'd0,  0);
    add("rst_locked",     1, 0, 1, 0,  1,  0, 0, 0, 0, 0, 8'd0, -1);
    add("rst_resettle",   0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 8'd0, -1);
    add("lb_wait",        0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 8'd0, -1);
    add("lb_bs_start",    0, 0, 0, 0, 20,  3, 1, 0, 0, 0, 8'd1, -1);
    add("lb_bs_cyc2",     0, 0, 0, 0,  1,  3, 1, 0, 0, 0, 8'd1, -1);
    add("lb_los_sync",    0, 1, 0, 0,  2,  3, 1, 0, 0, 0, 8'd1, -1);
    add("lb_los",         0, 1, 0, 0,  1,  0, 0, 0, 0, 0, 8'd0, -1);
    add("force_ignored",  0, 1, 0, 1,  1,  0, 0, 0, 0, 0, 8'd0, -1);
    add("lb_release",     0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 8'd0, -1);
    add("lb_settle",      0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 8'd0, -1);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      sfp_los       = vecs[i].los;
      link_ready    = vecs[i].rdy;
      force_retrain = vecs[i].frc;
      exp_q.push_back({vecs[i].st, vecs[i].bs, vecs[i].tx, vecs[i].up, vecs[i].flt, vecs[i].retry});
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        tick();
        // a force request is a single-cycle pulse
        force_retrain = 1'b0;
      end
      exp_v = exp_q.pop_front();
      act_v = {state, bitslip_reset, tx_data_en, link_up, fault, retry_cnt};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL %s: got st=%0d bs=%b tx=%b up=%b flt=%b retry=%0d, want st=%0d bs=%b tx=%b up=%b flt=%b retry=%0d",
                 vecs[i].name, act_v[14:12], act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                 exp_v[14:12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
      if (vecs[i].bsc >= 0) begin
        tests++;
        if ((bs_hi_cnt - bs_base) != vecs[i].bsc) begin
          fails++;
          $display("FAIL %s_bitslip_cycles: got %0d want %0d", vecs[i].name,
                   bs_hi_cnt - bs_base, vecs[i].bsc);
        end
        bs_base = bs_hi_cnt;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
